// File: rtl/fifo_sync_param_pkg.sv
// Shared constants, helper function and status struct for the synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_DATA_W_DEF = 16;
    localparam int FIFO_DEPTH_DEF  = 128;

    function automatic int fifo_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bus of the synchronous FIFO; master drives requests, slave is the FIFO.
interface fifo_sync_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF
);

    localparam int CNT_W = fifo_clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_sync_param_mem.sv
// Flip-flop storage array: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [DATA_W-1:0] o_rdData
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count and threshold/error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = FIFO_DATA_W_DEF,
    parameter int DEPTH     = FIFO_DEPTH_DEF,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic clk,
    input  logic rst,
    fifo_sync_param_if.slave bus
);

    localparam int ADDR_W = fifo_clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [ADDR_W:0]   r_wrPtr;
    logic [ADDR_W:0]   r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    fifo_status_t      r_status;

    logic              w_rdAccept;
    logic              w_wrAccept;
    logic [CNT_W-1:0]  w_countNext;
    fifo_status_t      w_statusNext;
    logic [DATA_W-1:0] w_memRdData;

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign w_rdAccept = bus.rd_en && !r_status.empty;
    assign w_wrAccept = bus.wr_en && (!r_status.full || w_rdAccept);

    always_comb begin
        w_countNext = r_count;
        case ({w_wrAccept, w_rdAccept})
            2'b10:   w_countNext = r_count + 1'b1;
            2'b01:   w_countNext = r_count - 1'b1;
            default: w_countNext = r_count;
        endcase
    end

    always_comb begin
        w_statusNext              = '0;
        w_statusNext.full         = (w_countNext == CNT_W'(DEPTH));
        w_statusNext.empty        = (w_countNext == '0);
        w_statusNext.almost_full  = (w_countNext >= CNT_W'(AFULL_TH));
        w_statusNext.almost_empty = (w_countNext <= CNT_W'(AEMPTY_TH));
        w_statusNext.overflow     = bus.wr_en && !w_wrAccept;
        w_statusNext.underflow    = bus.rd_en && !w_rdAccept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr               <= '0;
            r_rdPtr               <= '0;
            r_count               <= '0;
            r_status              <= '0;
            r_status.empty        <= 1'b1;
            r_status.almost_empty <= 1'b1;
        end else begin
            if (w_wrAccept) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_rdAccept) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_count  <= w_countNext;
            r_status <= w_statusNext;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk      (clk),
        .i_wrEn   (w_wrAccept),
        .i_wrAddr (r_wrPtr[ADDR_W-1:0]),
        .i_wrData (bus.wr_data),
        .i_rdAddr (r_rdPtr[ADDR_W-1:0]),
        .o_rdData (w_memRdData)
    );

`ifdef FIFO_FWFT_EN
    assign bus.rd_data  = w_memRdData;
    assign bus.rd_valid = !r_status.empty;
`else
    logic [DATA_W-1:0] r_rdData;
    logic              r_rdValid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
        end else begin
            r_rdValid <= w_rdAccept;
            if (w_rdAccept) begin
                r_rdData <= w_memRdData;
            end
        end
    end

    assign bus.rd_data  = r_rdData;
    assign bus.rd_valid = r_rdValid;
`endif

    assign bus.full         = r_status.full;
    assign bus.empty        = r_status.empty;
    assign bus.almost_full  = r_status.almost_full;
    assign bus.almost_empty = r_status.almost_empty;
    assign bus.overflow     = r_status.overflow;
    assign bus.underflow    = r_status.underflow;
    assign bus.count        = r_count;

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock FIFO with configurable width, depth and almost-full/almost-empty thresholds. Supports simultaneous read and write, occupancy count and overflow/underflow flags. Sits between a producer and a consumer in the same clock domain, in place of the fixed 16-bit, 100-entry FIFO. Read mode is selectable at compile time: registered read or first-word-fall-through.

## Interface

**Parameters**
- `DATA_W`, default 16: word width in bits.
- `DEPTH`, default 128: number of entries. Must be a power of two and at least 4.
- `AFULL_TH`, default DEPTH-4: `almost_full` asserts when count >= AFULL_TH.
- `AEMPTY_TH`, default 4: `almost_empty` asserts when count <= AEMPTY_TH.

**Ports**
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `wr_en`, in, 1: write request.
- `wr_data`, in, DATA_W: write word.
- `rd_en`, in, 1: read (pop) request.
- `rd_data`, out, DATA_W: read word.
- `rd_valid`, out, 1: `rd_data` is valid.
- `full`, out, 1: count == DEPTH.
- `empty`, out, 1: count == 0.
- `almost_full`, out, 1: threshold flag.
- `almost_empty`, out, 1: threshold flag.
- `count`, out, $clog2(DEPTH)+1: current occupancy.
- `overflow`, out, 1: one-cycle pulse when a write is rejected.
- `underflow`, out, 1: one-cycle pulse when a read is rejected.

## Operation

- **Pointers:** `wr_ptr` and `rd_ptr` are ADDR_W+1 bits wide, where ADDR_W = $clog2(DEPTH). The MSB is the wrap bit.
  - empty: pointers are equal.
  - full: low bits are equal and MSBs differ.
  - Pointers wrap naturally modulo 2·DEPTH.
- **count:** a registered counter, +1 on an accepted write alone, −1 on an accepted read alone, unchanged on both or neither. All flags are registered and derived from the next-state count, so they are correct in the same cycle as `count`.
- **Write acceptance:** `wr_en && (!full || rd_accept)`. A write while full is accepted only if a read is accepted in the same cycle.
- **Read acceptance:** `rd_en && !empty`. A read while empty is always rejected, even with a same-cycle write.
- **Rejected operations:** no pointer, count or memory change. The matching `overflow` or `underflow` pulses high for exactly one cycle.
- **Reset (asynchronous, any time, including mid-burst):**
  - Pointers, count, `rd_data`, `rd_valid`, `overflow`, `underflow`, `full` and `almost_full` go to 0.
  - `empty` and `almost_empty` go to 1.
  - Memory contents are not reset.
  - The first accepted write after reset deassertion lands in entry 0.
- **Threshold equalities:** `almost_full` at count == AFULL_TH is 1. `almost_empty` at count == AEMPTY_TH is 1.

## Timing

- Registered-read mode (default):
  - An accepted read at edge N drives `rd_data` = head word and `rd_valid` = 1 after edge N. Latency is 1 cycle.
  - `rd_valid` is 0 in cycles with no accepted read. `rd_data` holds its last value.
- Write-to-read latency: a word written at edge N is readable from edge N+1 (`empty` falls after edge N).
- Flag latency: `full`, `empty`, thresholds and `count` update on the same edge as the pointer change.
- Back-to-back reads and writes every cycle sustain full throughput at any occupancy between 1 and DEPTH-1.

## Configuration

- `FIFO_FWFT_EN` defined: first-word-fall-through mode.
  - `rd_data` continuously shows the head word, read combinationally from the memory.
  - `rd_valid` = !empty.
  - `rd_en` pops the head, and the next word appears after the same edge.
  - Read latency is 0; write-to-`rd_valid` latency is 1 cycle.
- `FIFO_FWFT_EN` undefined: registered-read mode as described in Timing.
- Acceptance rules, flags and reset behaviour are identical in both modes.

## Structure

- Package `fifo_pkg`:
  - default constants `FIFO_DATA_W_DEF` = 16 and `FIFO_DEPTH_DEF` = 128;
  - function `fifo_clog2`;
  - typedef `fifo_status_t`, a packed struct of full, empty, almost_full, almost_empty, overflow, underflow.
- Sub-module `fifo_mem`: DEPTH×DATA_W flip-flop array with one write port and one asynchronous read port, no reset.
- Pointers, counter, flags and the read register live in the top module.

## Test plan

- **Reset and fill:** reset, then write 0x0001..0x0080 on 128 consecutive cycles.
  - `full` = 1 and `count` = 128 after the last edge.
  - `almost_full` rises when `count` reaches 124.
- **Overflow:** with the FIFO full, pulse `wr_en` with 0xDEAD.
  - `overflow` = 1 for one cycle, `count` stays 128.
  - Draining returns 0x0001..0x0080 in order, with no 0xDEAD.
- **Underflow with simultaneous write:** with the FIFO empty, assert `rd_en` and `wr_en` (0x1234) together.
  - `underflow` pulses and `count` = 1.
  - The next read returns 0x1234.
- **Full with simultaneous read and write:** at count 128, assert both with write data 0xBEEF.
  - `count` stays 128 and `overflow` = 0.
  - 0xBEEF emerges after 127 further reads.
- **Wrap-around:** stream 300 words, keeping occupancy at 3, with concurrent reads and writes.
  - Output sequence matches input and `empty` never asserts mid-stream.
- **Asynchronous reset mid-burst and FWFT:**
  - Assert `rst` between edges at count 50: `empty` = 1 and `count` = 0 immediately.
  - With `FIFO_FWFT_EN`: after a write of 0x00AA, `rd_data` = 0x00AA with `rd_valid` = 1 before any `rd_en`.
